// File: rtl/n1_ir.sv
// Instruction register: current IR with forced loads, a one-deep stash for
// prefetched opcodes, and combinational decode flags for flow control.
module n1_ir #(
  parameter logic [15:0] DROP_OPC = 16'h0001,
  parameter logic [15:0] NOP_OPC  = 16'h0000
) (
  input  logic        clk_i,
  input  logic        sync_rst_i,
  input  logic [15:0] pbus_dat_i,
  input  logic        fc2ir_capture_i,
  input  logic        fc2ir_stash_i,
  input  logic        fc2ir_expend_i,
  input  logic        fc2ir_force_eow_i,
  input  logic        fc2ir_force_0call_i,
  input  logic        fc2ir_force_call_i,
  input  logic        fc2ir_force_drop_i,
  input  logic        fc2ir_force_nop_i,
  output logic        ir2fc_eow_o,
  output logic        ir2fc_eow_postpone_o,
  output logic        ir2fc_jump_or_call_o,
  output logic        ir2fc_bra_o,
  output logic        ir2fc_scyc_o,
  output logic        ir2fc_mem_o,
  output logic        ir2fc_mem_rd_o,
  output logic        ir2fc_madr_sel_o,
  output logic [15:0] ir_cur_o,
  output logic        ir_stash_vld_o,
  output logic [15:0] prb_ir_o,
  output logic [15:0] prb_ir_stash_o
);

  localparam logic [15:0] CALL0_OPC = 16'h6000;

  logic [15:0] ir_cur_q, ir_cur_d;
  logic [15:0] ir_stash_q, ir_stash_d;
  logic        stash_vld_q, stash_vld_d;
  logic [15:0] ir_sel_s;

  // Next current-IR value; forces win over expend, which wins over capture.
  always_comb begin
    ir_sel_s = ir_cur_q;
    if (fc2ir_force_0call_i) begin
      ir_sel_s = CALL0_OPC;
    end else if (fc2ir_force_call_i) begin
      ir_sel_s = {3'b011, pbus_dat_i[12:0]};
    end else if (fc2ir_force_drop_i) begin
      ir_sel_s = DROP_OPC;
    end else if (fc2ir_force_nop_i) begin
      ir_sel_s = NOP_OPC;
    end else if (fc2ir_expend_i) begin
      ir_sel_s = stash_vld_q ? ir_stash_q : NOP_OPC;
    end else if (fc2ir_capture_i) begin
      ir_sel_s = pbus_dat_i;
    end else begin
      ir_sel_s = ir_cur_q;
    end
    ir_cur_d = ir_sel_s | {fc2ir_force_eow_i, 15'h0000};
  end

  // Stash is consumed by any expend, even one overridden by a force.
  always_comb begin
    ir_stash_d  = ir_stash_q;
    stash_vld_d = stash_vld_q;
    if (fc2ir_stash_i) begin
      ir_stash_d  = pbus_dat_i;
      stash_vld_d = 1'b1;
    end else if (fc2ir_expend_i) begin
      ir_stash_d  = ir_stash_q;
      stash_vld_d = 1'b0;
    end else begin
      ir_stash_d  = ir_stash_q;
      stash_vld_d = stash_vld_q;
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!sync_rst_i) begin
      ir_cur_q    <= CALL0_OPC;
      ir_stash_q  <= 16'h0000;
      stash_vld_q <= 1'b0;
    end else begin
      ir_cur_q    <= ir_cur_d;
      ir_stash_q  <= ir_stash_d;
      stash_vld_q <= stash_vld_d;
    end
  end

  // Decode of the current IR.
  always_comb begin
    ir2fc_eow_o          = ir_cur_q[15];
    ir2fc_jump_or_call_o = ir_cur_q[14];
    ir2fc_bra_o          = (ir_cur_q[14:13] == 2'b01);
    ir2fc_mem_o          = (ir_cur_q[14:13] == 2'b00) & ir_cur_q[12];
    ir2fc_scyc_o         = (ir_cur_q[14:13] == 2'b00) & ~ir_cur_q[12];
    ir2fc_mem_rd_o       = ir2fc_mem_o & ir_cur_q[11];
    ir2fc_madr_sel_o     = ir2fc_mem_o & ir_cur_q[10];
    ir2fc_eow_postpone_o = ir_cur_q[15] &
                           (ir2fc_jump_or_call_o | ir2fc_bra_o | ir2fc_mem_o);
  end

  assign ir_cur_o       = ir_cur_q;
  assign prb_ir_o       = ir_cur_q;
  assign prb_ir_stash_o = ir_stash_q;
  assign ir_stash_vld_o = stash_vld_q;

endmodule

// File: tb/tb_n1_ir.sv
// Directed, table-driven bench for n1_ir; each record is one clock of stimulus
// and the hand-computed register and decode state expected after that edge.
module tb_n1_ir;

  localparam logic [7:0] CAP  = 8'h80;
  localparam logic [7:0] STH  = 8'h40;
  localparam logic [7:0] EXP  = 8'h20;
  localparam logic [7:0] FEOW = 8'h10;
  localparam logic [7:0] F0C  = 8'h08;
  localparam logic [7:0] FCAL = 8'h04;
  localparam logic [7:0] FDRP = 8'h02;
  localparam logic [7:0] FNOP = 8'h01;
  localparam logic [7:0] NONE = 8'h00;

  // flags order: eow, eow_postpone, jump_or_call, bra, scyc, mem, mem_rd, madr_sel
  typedef struct packed {
    logic        rst_n;
    logic [7:0]  ctl;
    logic [15:0] pbus;
    logic [15:0] exp_ir;
    logic [15:0] exp_stash;
    logic        exp_vld;
    logic [7:0]  exp_flags;
  } vec_t;

  logic        clk = 1'b0;
  logic        sync_rst = 1'b0;
  logic [15:0] pbus = 16'h0000;
  logic [7:0]  ctl = 8'h00;
  logic        eow, eow_pp, joc, bra, scyc, mem, mem_rd, madr;
  logic [15:0] ir_cur, prb_ir, prb_stash;
  logic        stash_vld;
  logic [7:0]  flags;

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  n1_ir dut (
    .clk_i(clk), .sync_rst_i(sync_rst), .pbus_dat_i(pbus),
    .fc2ir_capture_i(ctl[7]), .fc2ir_stash_i(ctl[6]), .fc2ir_expend_i(ctl[5]),
    .fc2ir_force_eow_i(ctl[4]), .fc2ir_force_0call_i(ctl[3]),
    .fc2ir_force_call_i(ctl[2]), .fc2ir_force_drop_i(ctl[1]),
    .fc2ir_force_nop_i(ctl[0]),
    .ir2fc_eow_o(eow), .ir2fc_eow_postpone_o(eow_pp),
    .ir2fc_jump_or_call_o(joc), .ir2fc_bra_o(bra), .ir2fc_scyc_o(scyc),
    .ir2fc_mem_o(mem), .ir2fc_mem_rd_o(mem_rd), .ir2fc_madr_sel_o(madr),
    .ir_cur_o(ir_cur), .ir_stash_vld_o(stash_vld),
    .prb_ir_o(prb_ir), .prb_ir_stash_o(prb_stash)
  );

  assign flags = {eow, eow_pp, joc, bra, scyc, mem, mem_rd, madr};

  task automatic add(input logic r, input logic [7:0] c, input logic [15:0] p,
                     input logic [15:0] ei, input logic [15:0] es,
                     input logic ev, input logic [7:0] ef);
    vec_t v;
    v.rst_n = r; v.ctl = c; v.pbus = p;
    v.exp_ir = ei; v.exp_stash = es; v.exp_vld = ev; v.exp_flags = ef;
    vecs.push_back(v);
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  // Drive one cycle of stimulus away from the edge, then sample just after it.
  task automatic step(input logic r, input logic [7:0] c, input logic [15:0] p);
    @(negedge clk);
    sync_rst = r; ctl = c; pbus = p;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [15:0] ei,
                             input logic [15:0] es, input logic ev, input logic [7:0] ef);
    check16({tag, " ir_cur"}, ir_cur, ei);
    check16({tag, " prb_ir"}, prb_ir, ei);
    check16({tag, " stash"}, prb_stash, es);
    check8({tag, " vld"}, {7'd0, stash_vld}, {7'd0, ev});
    check8({tag, " flags"}, flags, ef);
  endtask

  initial begin
    add(1'b0, CAP,              16'h1C00, 16'h6000, 16'h0000, 1'b0, 8'b0010_0000);
    add(1'b1, CAP,              16'h1C00, 16'h1C00, 16'h0000, 1'b0, 8'b0000_0111);
    add(1'b1, CAP,              16'h8005, 16'h8005, 16'h0000, 1'b0, 8'b1000_1000);
    add(1'b1, CAP,              16'hA123, 16'hA123, 16'h0000, 1'b0, 8'b1101_0000);
    add(1'b1, STH,              16'h2010, 16'hA123, 16'h2010, 1'b1, 8'b1101_0000);
    add(1'b1, EXP,              16'h0000, 16'h2010, 16'h2010, 1'b0, 8'b0001_0000);
    add(1'b1, STH,              16'h0042, 16'h2010, 16'h0042, 1'b1, 8'b0001_0000);
    add(1'b1, EXP | STH,        16'h0055, 16'h0042, 16'h0055, 1'b1, 8'b0000_1000);
    add(1'b1, FCAL | FNOP | CAP, 16'hFFFF, 16'h7FFF, 16'h0055, 1'b1, 8'b0010_0000);
    add(1'b1, FEOW,             16'h0000, 16'hFFFF, 16'h0055, 1'b1, 8'b1110_0000);
    add(1'b1, EXP | FDRP,       16'h0000, 16'h0001, 16'h0055, 1'b0, 8'b0000_1000);
    add(1'b1, EXP,              16'h0000, 16'h0000, 16'h0055, 1'b0, 8'b0000_1000);
    add(1'b1, F0C | CAP,        16'h1234, 16'h6000, 16'h0055, 1'b0, 8'b0010_0000);
    add(1'b1, CAP | FEOW,       16'h0C00, 16'h8C00, 16'h0055, 1'b0, 8'b1000_1000);
    add(1'b1, CAP,              16'h1800, 16'h1800, 16'h0055, 1'b0, 8'b0000_0110);
    add(1'b1, CAP,              16'h9400, 16'h9400, 16'h0055, 1'b0, 8'b1100_0101);
    add(1'b1, CAP,              16'h4000, 16'h4000, 16'h0055, 1'b0, 8'b0010_0000);
    add(1'b1, STH,              16'h1111, 16'h4000, 16'h1111, 1'b1, 8'b0010_0000);
    add(1'b0, CAP | EXP,        16'hABCD, 16'h6000, 16'h0000, 1'b0, 8'b0010_0000);
    add(1'b1, EXP,              16'h0000, 16'h0000, 16'h0000, 1'b0, 8'b0000_1000);
    add(1'b1, FDRP | FCAL,      16'hE5A5, 16'h65A5, 16'h0000, 1'b0, 8'b0010_0000);
    add(1'b1, NONE,             16'hFFFF, 16'h65A5, 16'h0000, 1'b0, 8'b0010_0000);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].ctl, vecs[i].pbus);
      check_state($sformatf("vec%0d", i), vecs[i].exp_ir, vecs[i].exp_stash,
                  vecs[i].exp_vld, vecs[i].exp_flags);
    end

    // Expend and stash together on an empty stash: NOP goes in, new stash is valid.
    step(1'b1, EXP | STH, 16'h3C3C);
    check_state("seq_empty_exp_sth", 16'h0000, 16'h3C3C, 1'b1, 8'b0000_1000);
    // Force NOP while expending a valid stash consumes it without loading it.
    step(1'b1, EXP | FNOP | FEOW, 16'h0000);
    check_state("seq_fnop_exp", 16'h8000, 16'h3C3C, 1'b0, 8'b1000_1000);
    // Reset with every force active still lands on CALL 0.
    step(1'b1, STH, 16'h2222);
    step(1'b0, 8'hFF, 16'h5555);
    check_state("seq_rst_all", 16'h6000, 16'h0000, 1'b0, 8'b0010_0000);
    step(1'b1, EXP, 16'h0000);
    check_state("seq_rst_exp", 16'h0000, 16'h0000, 1'b0, 8'b0000_1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
